// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the processor M stage.
// Holds the word-addressed data RAM plus a four-word MMIO window
// (cycle counter, LED register, store counter, reserved/error-clear).
// Read data is registered: q_dmem carries the value for the address
// presented in the previous cycle. There is no handshake; every cycle
// is an access and the responder never stalls the pipeline.
// Optional build macro: DMEM_ACCESS_ERR_EN enables the sticky
// out-of-range flag on access_err (otherwise it is tied to 0).
module dmem_responder #(
   parameter int          ADDR_BITS = 12,
   parameter logic [31:0] MMIO_BASE = 32'h0000_F000,
   parameter int          LED_W     = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      address_dmem,
   input  logic [31:0]      data,
   input  logic             wren,
   output logic [31:0]      q_dmem,
   output logic [LED_W-1:0] led_out,
   output logic             access_err
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [31:0]          mem [DEPTH];

   logic                 ram_hit;
   logic                 mmio_hit;
   logic                 unmapped;
   logic [ADDR_BITS-1:0] ram_idx;
   logic [31:0]          mmio_off;
   logic [31:0]          rd_val;
   logic                 ram_we;

   logic [31:0]          q_dmem_q,    q_dmem_d;
   logic [31:0]          cycle_cnt_q, cycle_cnt_d;
   logic [31:0]          store_cnt_q, store_cnt_d;
   logic [LED_W-1:0]     led_q,       led_d;

   // Address decode: RAM below 2**ADDR_BITS, MMIO at MMIO_BASE..MMIO_BASE+3
   always_comb begin
      ram_hit  = (address_dmem[31:ADDR_BITS] == '0);
      ram_idx  = address_dmem[ADDR_BITS-1:0];
      mmio_off = address_dmem - MMIO_BASE;
      mmio_hit = !ram_hit && (address_dmem >= MMIO_BASE) && (mmio_off < 32'd4);
      unmapped = !ram_hit && !mmio_hit;
   end

   // Read mux; sampled into q_dmem at the edge, so RAM and led reads see pre-write values
   always_comb begin
      rd_val = '0;
      if (ram_hit) begin
         rd_val = mem[ram_idx];
      end else if (mmio_hit) begin
         case (mmio_off[1:0])
            2'd0:    rd_val = cycle_cnt_q;
            2'd1:    rd_val = {{(32-LED_W){1'b0}}, led_q};
            2'd2:    rd_val = store_cnt_q;
            default: rd_val = '0;
         endcase
      end
   end

   // Next-state for read data, counters, LED register and RAM write strobe
   always_comb begin
      q_dmem_d    = rd_val;
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      store_cnt_d = store_cnt_q;
      led_d       = led_q;
      ram_we      = 1'b0;
      if (wren) begin
         if (ram_hit) begin
            ram_we      = 1'b1;
            store_cnt_d = store_cnt_q + 32'd1;
         end else if (mmio_hit && (mmio_off[1:0] == 2'd1)) begin
            led_d       = data[LED_W-1:0];
            store_cnt_d = store_cnt_q + 32'd1;
         end
      end
   end

   // Register state; reset overrides any access in the same cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         q_dmem_q    <= '0;
         cycle_cnt_q <= '0;
         store_cnt_q <= '0;
         led_q       <= '0;
      end else begin
         q_dmem_q    <= q_dmem_d;
         cycle_cnt_q <= cycle_cnt_d;
         store_cnt_q <= store_cnt_d;
         led_q       <= led_d;
      end
   end

   // RAM array: not cleared by reset, but a write during reset is dropped
   always_ff @(posedge clock) begin
      if (!reset && ram_we) begin
         mem[ram_idx] <= data;
      end
   end

`ifdef DMEM_ACCESS_ERR_EN
   logic access_err_q, access_err_d;

   // Sticky error flag: set by any unmapped access, cleared by writing 1 to offset 3
   always_comb begin
      access_err_d = access_err_q | unmapped;
      if (wren && mmio_hit && (mmio_off[1:0] == 2'd3) && data[0]) begin
         access_err_d = 1'b0;
      end
   end

   // Error flag register
   always_ff @(posedge clock) begin
      if (reset) begin
         access_err_q <= 1'b0;
      end else begin
         access_err_q <= access_err_d;
      end
   end

   assign access_err = access_err_q;
`else
   logic unused_unmapped;
   assign unused_unmapped = unmapped;
   assign access_err      = 1'b0;
`endif

   assign q_dmem  = q_dmem_q;
   assign led_out = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus random stimulus for dmem_responder,
// checked cycle by cycle against a behavioural model of the memory map.
module tb_dmem_responder;

   localparam logic [31:0] MMIO_BASE = 32'h0000_F000;
   localparam int          RAM_WORDS = 4096;

   logic        clock;
   logic        reset;
   logic [31:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_dmem;
   logic [15:0] led_out;
   logic        access_err;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model state
   logic [31:0] mem_m [int];
   logic [31:0] cyc_m;
   logic [31:0] stores_m;
   logic [15:0] led_m;
   logic        err_m;

   dmem_responder dut (
      .clock        (clock),
      .reset        (reset),
      .address_dmem (address_dmem),
      .data         (data),
      .wren         (wren),
      .q_dmem       (q_dmem),
      .led_out      (led_out),
      .access_err   (access_err)
   );

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive, model the edge, then check the registered outputs
   task automatic step(input logic [31:0] addr, input logic [31:0] wd,
                       input logic we, input logic rst);
      logic [31:0] exp_q;
      logic        known;
      logic        err_en;
      logic [31:0] off;
`ifdef DMEM_ACCESS_ERR_EN
      err_en = 1'b1;
`else
      err_en = 1'b0;
`endif
      address_dmem = addr;
      data         = wd;
      wren         = we;
      reset        = rst;
      known        = 1'b1;
      exp_q        = 32'h0;
      off          = addr - MMIO_BASE;
      if (rst) begin
         cyc_m    = 32'h0;
         stores_m = 32'h0;
         led_m    = 16'h0;
         err_m    = 1'b0;
      end else begin
         // read value from state before the edge
         if (addr < RAM_WORDS) begin
            if (mem_m.exists(int'(addr))) exp_q = mem_m[int'(addr)];
            else known = 1'b0;
         end else if (addr >= MMIO_BASE && off < 4) begin
            if (off == 0) exp_q = cyc_m;
            else if (off == 1) exp_q = {16'h0, led_m};
            else if (off == 2) exp_q = stores_m;
         end
         // write effects
         if (we) begin
            if (addr < RAM_WORDS) begin
               mem_m[int'(addr)] = wd;
               stores_m++;
            end else if (addr >= MMIO_BASE && off == 1) begin
               led_m = wd[15:0];
               stores_m++;
            end else if (addr >= MMIO_BASE && off == 3 && wd[0] && err_en) begin
               err_m = 1'b0;
            end
         end
         if (err_en && !(addr < RAM_WORDS) && !(addr >= MMIO_BASE && off < 4)) err_m = 1'b1;
         cyc_m++;
      end
      @(posedge clock);
      #1;
      if (known) chk("q_dmem", q_dmem, exp_q);
      chk("led_out", {16'h0, led_out}, {16'h0, led_m});
      chk("access_err", {31'h0, access_err}, {31'h0, err_m});
   endtask

   // Stimulus
   initial begin
      logic [31:0] a;
      logic [31:0] first_cnt;
      address_dmem = 32'h0;
      data         = 32'h0;
      wren         = 1'b0;
      reset        = 1'b1;
      cyc_m        = 32'h0;
      stores_m     = 32'h0;
      led_m        = 16'h0;
      err_m        = 1'b0;

      step(32'h0, 32'h0, 1'b0, 1'b1);
      chk("q_after_reset", q_dmem, 32'h0);

      // write then read back
      step(32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
      step(32'd5, 32'h0, 1'b0, 1'b0);
      chk("ram_readback", q_dmem, 32'hDEAD_BEEF);

      // read-first on same-cycle write
      step(32'd7, 32'h0000_1111, 1'b1, 1'b0);
      step(32'd7, 32'h0000_2222, 1'b1, 1'b0);
      chk("read_first", q_dmem, 32'h0000_1111);
      step(32'd7, 32'h0, 1'b0, 1'b0);
      chk("new_word", q_dmem, 32'h0000_2222);

      // LED register
      step(MMIO_BASE + 1, 32'h0001_ABCD, 1'b1, 1'b0);
      chk("led_value", {16'h0, led_out}, 32'h0000_ABCD);
      step(MMIO_BASE + 1, 32'h0, 1'b0, 1'b0);
      chk("led_read", q_dmem, 32'h0000_ABCD);

      // cycle counter: write ignored, consecutive reads differ by one
      step(MMIO_BASE, 32'h0, 1'b1, 1'b0);
      step(MMIO_BASE, 32'h0, 1'b0, 1'b0);
      first_cnt = q_dmem;
      step(MMIO_BASE, 32'h0, 1'b0, 1'b0);
      chk("cycle_delta", q_dmem - first_cnt, 32'd1);

      // store counter from a fresh reset: 3 RAM writes + ignored MMIO+0 write
      step(32'h0, 32'h0, 1'b0, 1'b1);
      step(32'd1, 32'hA1, 1'b1, 1'b0);
      step(32'd2, 32'hA2, 1'b1, 1'b0);
      step(32'd3, 32'hA3, 1'b1, 1'b0);
      step(MMIO_BASE, 32'hFF, 1'b1, 1'b0);
      step(MMIO_BASE + 2, 32'h0, 1'b0, 1'b0);
      chk("store_cnt", q_dmem, 32'd3);

      // unmapped read/write, then clear via offset 3
      step(32'h0000_8000, 32'h1234_5678, 1'b1, 1'b0);
      chk("unmapped_q", q_dmem, 32'h0);
      step(MMIO_BASE + 2, 32'h0, 1'b0, 1'b0);
      chk("unmapped_no_count", q_dmem, 32'd3);
      step(MMIO_BASE + 3, 32'h1, 1'b1, 1'b0);
      step(32'd4095, 32'hCAFE_0001, 1'b1, 1'b0);
      step(32'd4096, 32'h0, 1'b1, 1'b0);
      step(32'd4095, 32'h0, 1'b0, 1'b0);
      chk("ram_top_intact", q_dmem, 32'hCAFE_0001);

      // reset mid-stream suppresses the write to address 3
      step(32'd3, 32'h55, 1'b1, 1'b1);
      chk("rst_q", q_dmem, 32'h0);
      step(32'd3, 32'h0, 1'b0, 1'b0);
      chk("rst_write_dropped", q_dmem, 32'hA3);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: a = 32'($urandom_range(0, 15));
            5:             a = 32'd4095;
            6, 7:          a = MMIO_BASE + 32'($urandom_range(0, 3));
            8:             a = ($urandom_range(0, 1) == 0) ? 32'h0000_8000 : (MMIO_BASE + 32'd4);
            default:       a = 32'd4096;
         endcase
         step(a, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
